// File: rtl/bram_burst_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bram_burst_ctrl_if                                           |
// | Description : Bus bundle for bram_burst_ctrl. Carries the command/status   |
// |               lines, the write-data input stream, the read-data output     |
// |               stream and one block-RAM port.                               |
// |               master : the burst controller side                           |
// |               slave  : the command issuer / stream endpoints / RAM side    |
// | Signals     : start, cmd_we, cmd_addr, cmd_len      command                |
// |               busy, done, err                       status                 |
// |               s_data, s_valid, s_ready              write stream           |
// |               m_data, m_valid, m_ready              read stream            |
// |               mem_en, mem_we, mem_addr, mem_d, mem_q RAM port              |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface bram_burst_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
);
  // command / status
  logic                  start;
  logic                  cmd_we;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic                  busy;
  logic                  done;
  logic                  err;
  // write stream
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;
  // read stream
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  // RAM port
  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_d;
  logic [DATA_WIDTH-1:0] mem_q;

  modport master (
    input  start, cmd_we, cmd_addr, cmd_len,
    input  s_data, s_valid, m_ready, mem_q,
    output busy, done, err, s_ready, m_data, m_valid,
    output mem_en, mem_we, mem_addr, mem_d
  );

  modport slave (
    output start, cmd_we, cmd_addr, cmd_len,
    output s_data, s_valid, m_ready, mem_q,
    input  busy, done, err, s_ready, m_data, m_valid,
    input  mem_en, mem_we, mem_addr, mem_d
  );
endinterface

`default_nettype wire

// File: rtl/bram_burst_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bram_burst_ctrl                                              |
// | Description : Sequential write/read burst initiator for one port of a      |
// |               block RAM with 1-cycle registered read latency. Write data   |
// |               comes in on a valid/ready stream, read data leaves on a      |
// |               valid/ready stream with full backpressure.                   |
// | Ports       : clk       clock, rising edge                                 |
// |               rst       asynchronous active-high reset                     |
// |               bus       bram_burst_ctrl_if.master (command, status,        |
// |                         write stream, read stream, RAM port)               |
// | Options     : BRAM_CTRL_BOUND_CHK_EN - when defined, commands that run     |
// |               past MEM_SIZE are rejected with done+err; when undefined,    |
// |               err is tied low and addresses wrap.                          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module bram_burst_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int MEM_SIZE   = 4095,
  parameter int ADDR_WIDTH = $clog2(MEM_SIZE),
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input wire clk,
  input wire rst,
  bram_burst_ctrl_if.master bus
);

  localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0]  c_LEN_ONE  = LEN_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_rem;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_s_ready;
  logic                  r_mem_en;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_d;

  // Read pipeline: r_rd_issue marks a read address on the RAM port this
  // cycle, r_q_pend marks its data sitting on mem_q this cycle.
  logic                  r_rd_issue;
  logic                  r_q_pend;
  logic [DATA_WIDTH-1:0] r_buf [2];
  logic [1:0]            r_buf_cnt;
  logic                  r_buf_head;

  logic                  w_s_hs;
  logic                  w_buf_nonempty;
  logic                  w_head_valid;
  logic                  w_pop;
  logic                  w_buf_pop;
  logic                  w_push;
  logic [2:0]            w_occ_after;
  logic                  w_rd_issue;
  logic                  w_rd_last;
  logic                  w_reject;

`ifdef BRAM_CTRL_BOUND_CHK_EN
  localparam int                 c_END_W    = LEN_WIDTH + 1;
  localparam logic [c_END_W-1:0] c_MEM_SIZE = c_END_W'(MEM_SIZE);
  logic [c_END_W-1:0] w_cmd_end;
  logic               r_err;
  assign w_cmd_end = c_END_W'(bus.cmd_addr) + c_END_W'(bus.cmd_len);
  assign w_reject  = (bus.cmd_len != '0) && (w_cmd_end > c_MEM_SIZE);
  assign bus.err   = r_err;
`else
  assign w_reject  = 1'b0;
  assign bus.err   = 1'b0;
`endif

  assign w_s_hs         = bus.s_valid & r_s_ready;

  // The stream head is the oldest buffered word; with an empty buffer a
  // word arriving on mem_q is presented directly so the first read word
  // appears two cycles after start.
  assign w_buf_nonempty = (r_buf_cnt != 2'd0);
  assign w_head_valid   = w_buf_nonempty | r_q_pend;
  assign w_pop          = w_head_valid & bus.m_ready;
  assign w_buf_pop      = w_pop & w_buf_nonempty;
  assign w_push         = r_q_pend & ~(w_pop & ~w_buf_nonempty);

  // Words owned after this edge: buffered + on the RAM port + on mem_q,
  // minus any pop. Keeping this at most 2 guarantees every returning word
  // has a buffer slot, whatever m_ready does.
  assign w_occ_after    = {1'b0, r_buf_cnt} + {2'b00, r_rd_issue}
                        + {2'b00, r_q_pend} - {2'b00, w_pop};
  assign w_rd_issue     = (r_state == S_READ) && (r_rem != '0) && (w_occ_after < 3'd2);
  assign w_rd_last      = (r_state == S_READ) && (r_rem == '0) && (w_occ_after == 3'd0);

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.s_ready  = r_s_ready;
  assign bus.m_valid  = w_head_valid;
  assign bus.m_data   = w_buf_nonempty ? r_buf[r_buf_head] :
                        (r_q_pend ? bus.mem_q : '0);
  assign bus.mem_en   = r_mem_en;
  assign bus.mem_we   = r_mem_we;
  assign bus.mem_addr = r_mem_addr;
  assign bus.mem_d    = r_mem_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_rem      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_s_ready  <= 1'b0;
      r_mem_en   <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_d    <= '0;
      r_rd_issue <= 1'b0;
      r_q_pend   <= 1'b0;
      r_buf[0]   <= '0;
      r_buf[1]   <= '0;
      r_buf_cnt  <= 2'd0;
      r_buf_head <= 1'b0;
`ifdef BRAM_CTRL_BOUND_CHK_EN
      r_err      <= 1'b0;
`endif
    end else begin
      r_done     <= 1'b0;
      r_mem_en   <= 1'b0;
      r_mem_we   <= 1'b0;
      r_rd_issue <= 1'b0;
      r_q_pend   <= r_rd_issue;
`ifdef BRAM_CTRL_BOUND_CHK_EN
      r_err      <= 1'b0;
`endif

      // Buffer bookkeeping; the push slot uses pre-pop pointers so a
      // simultaneous push and pop keeps order.
      if (w_push) begin
        r_buf[r_buf_head ^ r_buf_cnt[0]] <= bus.mem_q;
      end
      r_buf_head <= r_buf_head ^ w_buf_pop;
      r_buf_cnt  <= r_buf_cnt + {1'b0, w_push} - {1'b0, w_buf_pop};

      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_addr <= bus.cmd_addr;
            r_rem  <= bus.cmd_len;
            if (w_reject) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
`ifdef BRAM_CTRL_BOUND_CHK_EN
              r_err   <= 1'b1;
`endif
            end else if (bus.cmd_len == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else if (bus.cmd_we) begin
              r_state   <= S_WRITE;
              r_busy    <= 1'b1;
              r_s_ready <= 1'b1;
            end else begin
              // First read goes out on the start edge to save a cycle.
              r_state    <= S_READ;
              r_busy     <= 1'b1;
              r_mem_en   <= 1'b1;
              r_mem_addr <= bus.cmd_addr;
              r_addr     <= bus.cmd_addr + c_ADDR_ONE;
              r_rem      <= bus.cmd_len - c_LEN_ONE;
              r_rd_issue <= 1'b1;
            end
          end
        end

        S_WRITE: begin
          if (w_s_hs) begin
            r_mem_en   <= 1'b1;
            r_mem_we   <= 1'b1;
            r_mem_addr <= r_addr;
            r_mem_d    <= bus.s_data;
            r_addr     <= r_addr + c_ADDR_ONE;
            r_rem      <= r_rem - c_LEN_ONE;
            if (r_rem == c_LEN_ONE) begin
              r_s_ready <= 1'b0;
            end
          end else if (r_rem == '0) begin
            // The last write is on the RAM port this cycle; finish after it.
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end

        S_READ: begin
          if (w_rd_issue) begin
            r_mem_en   <= 1'b1;
            r_mem_addr <= r_addr;
            r_addr     <= r_addr + c_ADDR_ONE;
            r_rem      <= r_rem - c_LEN_ONE;
            r_rd_issue <= 1'b1;
          end
          if (w_rd_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bram_burst_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_bram_burst_ctrl                                           |
// | Description : Directed self-checking bench for bram_burst_ctrl with a      |
// |               behavioural 1-cycle-latency RAM on the controller port.      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_bram_burst_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bram_burst_ctrl_if #(.DATA_WIDTH(16), .ADDR_WIDTH(12), .LEN_WIDTH(13)) bus ();

  bram_burst_ctrl #(.DATA_WIDTH(16), .MEM_SIZE(4095)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // RAM with registered read data
  logic [15:0] ram [4096];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_d;
      else            bus.mem_q <= ram[bus.mem_addr];
    end
  end

  // Event logs, sampled on the falling edge
  logic [11:0] wr_addr [$];
  logic [15:0] wr_data [$];
  int          wr_cyc  [$];
  logic [15:0] pop_data[$];
  int          pop_cyc [$];
  int          done_cyc[$];
  int          err_cyc [$];
  int          en_cnt, rd_issued, pop_cnt, out_max, busy_cnt;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_en) en_cnt++;
      if (bus.mem_en && bus.mem_we) begin
        wr_addr.push_back(bus.mem_addr);
        wr_data.push_back(bus.mem_d);
        wr_cyc.push_back(cyc);
      end
      if (bus.mem_en && !bus.mem_we) rd_issued++;
      // words read so far but not yet delivered, including this cycle's read
      if (rd_issued - pop_cnt > out_max) out_max = rd_issued - pop_cnt;
      if (bus.m_valid && bus.m_ready) begin
        pop_data.push_back(bus.m_data);
        pop_cyc.push_back(cyc);
        pop_cnt++;
      end
      if (bus.done) done_cyc.push_back(cyc);
      if (bus.err)  err_cyc.push_back(cyc);
      if (bus.busy) busy_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic int q0(input int q[$]);
    return (q.size() > 0) ? q[0] : -1;
  endfunction

  task automatic clear_logs();
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    pop_data.delete(); pop_cyc.delete(); done_cyc.delete(); err_cyc.delete();
    en_cnt = 0; rd_issued = 0; pop_cnt = 0; out_max = 0; busy_cnt = 0;
  endtask

  // gap=0: s_valid held high; gap=N: s_valid high every Nth cycle
  task automatic do_write(input logic [11:0] addr, input logic [12:0] len,
                          input logic [15:0] d0, input int gap, output int st);
    int idx;
    idx = 0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.cmd_we = 1'b1; bus.cmd_addr = addr; bus.cmd_len = len;
    st = cyc;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (idx < int'(len)) begin
        bus.s_valid = (gap <= 1) ? 1'b1 : ((k % gap) == gap - 1);
        bus.s_data  = d0 + 16'(idx);
      end else begin
        bus.s_valid = 1'b0;
      end
      if (done_cyc.size() != 0) break;
      @(negedge clk);
      if (bus.s_valid && bus.s_ready) idx++;
    end
    bus.s_valid = 1'b0;
    check("wr_done_seen", done_cyc.size() != 0, 1);
  endtask

  // mode 0: m_ready held high; mode 1: m_ready 1,0,0 repeating.
  // pulse>0: a write start is pulsed that many cycles after start.
  task automatic do_read(input logic [11:0] addr, input logic [12:0] len,
                         input int mode, input int pulse, output int st);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.cmd_we = 1'b0; bus.cmd_addr = addr; bus.cmd_len = len;
    st = cyc;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      bus.start = (pulse == k + 1);
      if (bus.start) begin
        bus.cmd_we = 1'b1; bus.cmd_addr = 12'h050; bus.cmd_len = 13'd2;
      end
      bus.m_ready = (mode == 0) ? 1'b1 : ((k % 3) == 0);
      if (done_cyc.size() != 0) break;
    end
    bus.start = 1'b0;
    bus.m_ready = 1'b0;
    check("rd_done_seen", done_cyc.size() != 0, 1);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"},    bus.busy,    0);
    check({tag, "_done"},    bus.done,    0);
    check({tag, "_err"},     bus.err,     0);
    check({tag, "_s_ready"}, bus.s_ready, 0);
    check({tag, "_m_valid"}, bus.m_valid, 0);
    check({tag, "_mem_en"},  bus.mem_en,  0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    bus.start = 1'b0; bus.cmd_we = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.s_data = '0; bus.s_valid = 1'b0; bus.m_ready = 1'b0;
    clear_logs();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_quiet("rst");
    check("rst_mem_we",   bus.mem_we,   0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_d",    bus.mem_d,    0);
    check("rst_m_data",   bus.m_data,   0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Write 0x010..0x013 with A001..A004
    clear_logs();
    do_write(12'h010, 13'd4, 16'hA001, 0, st);
    check("wr1_count", wr_addr.size(), 4);
    for (int i = 0; i < 4 && i < wr_addr.size(); i++) begin
      check("wr1_addr", wr_addr[i], 12'h010 + i);
      check("wr1_data", wr_data[i], 16'hA001 + i);
      check("wr1_cyc",  wr_cyc[i],  st + 2 + i);
    end
    check("wr1_done_cyc", q0(done_cyc), st + 6);

    // Read back with m_ready high
    clear_logs();
    do_read(12'h010, 13'd4, 0, 0, st);
    check("rd1_count", pop_data.size(), 4);
    for (int i = 0; i < 4 && i < pop_data.size(); i++) begin
      check("rd1_data", pop_data[i], 16'hA001 + i);
      check("rd1_cyc",  pop_cyc[i],  st + 2 + i);
    end
    check("rd1_done_cyc", q0(done_cyc), st + 6);
    check("rd1_reads", rd_issued, 4);

    // Read backpressure: 8 words, m_ready 1,0,0,...
    clear_logs();
    do_write(12'h100, 13'd8, 16'hB000, 0, st);
    check("wr2_count", wr_addr.size(), 8);
    clear_logs();
    do_read(12'h100, 13'd8, 1, 0, st);
    check("bp_count", pop_data.size(), 8);
    for (int i = 0; i < 8 && i < pop_data.size(); i++) begin
      check("bp_data", pop_data[i], 16'hB000 + i);
      check("bp_cyc",  pop_cyc[i],  st + 4 + 3 * i);
    end
    check("bp_done_cyc", q0(done_cyc), st + 26);
    check("bp_reads", rd_issued, 8);
    check("bp_outstanding_le2", out_max <= 2, 1);

    // Write with s_valid every third cycle
    clear_logs();
    do_write(12'h200, 13'd3, 16'hC001, 3, st);
    check("gap_count", wr_addr.size(), 3);
    for (int i = 0; i < 3 && i < wr_addr.size(); i++) begin
      check("gap_addr", wr_addr[i], 12'h200 + i);
      check("gap_data", wr_data[i], 16'hC001 + i);
      check("gap_cyc",  wr_cyc[i],  st + 4 + 3 * i);
    end
    check("gap_done_cyc", q0(done_cyc), st + 11);
    check("gap_busy_cycles", busy_cnt, 10);

    // Zero length
    clear_logs();
    do_write(12'h300, 13'd0, 16'h0000, 0, st);
    repeat (3) @(posedge clk);
    #1;
    check("zl_done_cyc", q0(done_cyc), st + 1);
    check("zl_done_n", done_cyc.size(), 1);
    check("zl_busy", busy_cnt, 0);
    check("zl_mem_en", en_cnt, 0);

    // Start pulsed mid-read is ignored
    clear_logs();
    do_read(12'h010, 13'd4, 0, 2, st);
    repeat (3) @(posedge clk);
    #1;
    check("ign_count", pop_data.size(), 4);
    for (int i = 0; i < 4 && i < pop_data.size(); i++) begin
      check("ign_data", pop_data[i], 16'hA001 + i);
    end
    check("ign_done_n", done_cyc.size(), 1);
    check("ign_done_cyc", q0(done_cyc), st + 6);
    check("ign_writes", wr_addr.size(), 0);
    check("ign_mem_en", en_cnt, 4);

    // Reset while the 3rd word of a 6-word write is offered
    clear_logs();
    @(posedge clk); #1;
    bus.start = 1'b1; bus.cmd_we = 1'b1; bus.cmd_addr = 12'h400; bus.cmd_len = 13'd6;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.s_valid = 1'b1; bus.s_data = 16'hD001;
    @(posedge clk); #1;
    bus.s_data = 16'hD002;
    @(posedge clk); #1;
    bus.s_data = 16'hD003;
    rst = 1'b1;
    #1;
    check_quiet("mrst");
    @(posedge clk); #1;
    rst = 1'b0;
    bus.s_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mrst_done_n", done_cyc.size(), 0);
    check("mrst_writes", wr_addr.size(), 1);
    check("mrst_busy", bus.busy, 0);

    clear_logs();
    do_write(12'h410, 13'd2, 16'hE001, 0, st);
    check("post_count", wr_addr.size(), 2);
    for (int i = 0; i < 2 && i < wr_addr.size(); i++) begin
      check("post_addr", wr_addr[i], 12'h410 + i);
      check("post_data", wr_data[i], 16'hE001 + i);
    end
    check("post_done_cyc", q0(done_cyc), st + 4);

    // Boundary: 4090 + 6 > 4095
    clear_logs();
    do_write(12'd4090, 13'd6, 16'hF000, 0, st);
`ifdef BRAM_CTRL_BOUND_CHK_EN
    check("bnd_done_cyc", q0(done_cyc), st + 1);
    check("bnd_err_cyc",  q0(err_cyc),  st + 1);
    check("bnd_mem_en",   en_cnt, 0);
    check("bnd_busy",     busy_cnt, 0);
`else
    check("bnd_count", wr_addr.size(), 6);
    for (int i = 0; i < 6 && i < wr_addr.size(); i++) begin
      check("bnd_addr", wr_addr[i], 4090 + i);
    end
    check("bnd_err_n",    err_cyc.size(), 0);
    check("bnd_done_cyc", q0(done_cyc), st + 8);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
